router_in_queue: RTL and testbench
==================================

Name: router_in_queue

Overview:
- Input staging FIFO directly upstream of the combinational 60-input router.
- Accepts 60-bit request vectors (x0..x59 bit order, bit 0 = x0) from the request source over a valid/ready handshake.
- Presents the head entry to the router's inputs in first-word-fall-through form; the router's consumer pops it once the route decision is taken.
- Decouples request arrival from decision consumption and provides occupancy and a synchronous flush.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- WIDTH, 60, request vector width; bit i drives router input xi.
- CW, $clog2(DEPTH)+1, width of the occupancy count (derived, not overridden).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  asynchronous reset, active-high.
- flush  input  1  synchronous clear of all entries.
- in_valid  input  1  source has a request vector.
- in_ready  output  1  queue can accept; registered.
- in_data  input  WIDTH  request vector.
- out_valid  output  1  head entry present; registered.
- out_ready  input  1  consumer pops head this cycle.
- out_data  output  WIDTH  head entry, drives router x inputs.
- count  output  CW  entries currently held, 0..DEPTH.
- out_perr  output  1  head parity error (see Optional Feature).

Behaviour:
- Reset is asynchronous, active-high, on rst; clock is clk.
- Reset values: read pointer, write pointer and count = 0; out_valid = 0; in_ready = 0; out_perr = 0.
- in_ready rises on the first clk edge after rst deasserts.
- Storage contents are not reset; out_data is don't-care while out_valid = 0.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- Push writes in_data at the write pointer; the write pointer increments modulo DEPTH.
- Pop advances the read pointer modulo DEPTH.
- Pointers wrap naturally at DEPTH; no other wrap handling.
- count' = count + push - pop.
- out_valid' = (count' != 0); in_ready' = (count' != DEPTH).
- Both flags are registered; in_ready has no combinational path from out_ready.
- Latency: a push into an empty queue appears on out_data/out_valid the next cycle. No same-cycle bypass.
- Full: in_ready = 0. Push and pop in the same cycle when full is impossible by construction.
- Simultaneous push and pop with 0 < count < DEPTH: count unchanged, both pointers advance.
- Pop when count = 1 with simultaneous push: out_valid stays 1 and the new entry is head next cycle.
- Entries leave in strict FIFO order; out_data is stable while out_valid = 1 and out_ready = 0.
- flush has priority over push and pop in the same cycle:
  - pointers and count go to 0;
  - out_valid goes to 0 and in_ready goes to 1 on the next cycle;
  - any input offered during the flush cycle is discarded.
- Reset asserted mid-operation discards all contents immediately; outputs take reset values asynchronously.
- in_valid while in_ready = 0 is ignored. The source must hold in_data and in_valid until accepted.

Optional Feature:
- Macro: ROUTER_IN_QUEUE_PARITY_EN.
- Enabled:
  - each entry stores an extra even-parity bit computed from in_data at push;
  - out_perr = out_valid & (XOR of head data and stored parity bit);
  - out_perr is combinational from the registered head state;
  - flush and reset clear the parity storage validity together with the entries.
- Disabled: no parity storage; out_perr tied to 0. Port list is identical either way.

Test Plan:
- Release rst, hold in_valid=0 -> in_ready goes 0 to 1 one clk edge after release; out_valid=0, count=0.
- Push 0x0000000000000001, then 0x0FFFFFFFFFFFFFFF with out_ready=0 -> out_valid=1 one cycle after the first push, out_data=0x...01, count=2.
- Push 4 vectors with out_ready=0 (DEPTH=4) -> count=4, in_ready=0. Then a 5th in_valid is not accepted; pop returns the 4 vectors in order.
- count=2, push and pop in the same cycle for 8 cycles -> count stays 2, pointers wrap twice, output order matches input order.
- count=3, assert flush with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0, in_ready=1; the offered vector is never output.
- PARITY_EN defined: force a stored bit flip on the head entry -> out_perr=1 while that entry is head; after pop, out_perr=0. Undefined: out_perr=0 throughout.

Source files
------------

// File: rtl/router_in_queue.sv
// Input staging FIFO ahead of the 60-input router: first-word-fall-through, registered flags.
// Optional head parity check is enabled with `define ROUTER_IN_QUEUE_PARITY_EN.
module router_in_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 60,
  localparam int unsigned CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count,
  output logic             out_perr
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;
  logic             push, pop;
  logic             wr_en;

  assign push  = in_valid & in_ready_q;
  assign pop   = out_valid_q & out_ready;
  // Flush wins over any handshake in the same cycle, so the offered word is dropped.
  assign wr_en = push & ~flush;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      out_valid_d = 1'b0;
      in_ready_d  = 1'b1;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d     = count_q + CW'(push) - CW'(pop);
      out_valid_d = (count_d != '0);
      in_ready_d  = (count_d != CW'(DEPTH));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  // Storage is deliberately not reset; out_valid qualifies the head.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= in_data;
  end

  assign out_data  = mem_q[rd_ptr_q];
  assign out_valid = out_valid_q;
  assign in_ready  = in_ready_q;
  assign count     = count_q;

`ifdef ROUTER_IN_QUEUE_PARITY_EN
  logic par_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) par_q[wr_ptr_q] <= ^in_data;
  end

  // Even parity: data XOR stored bit is zero for an intact entry.
  assign out_perr = out_valid_q & ((^mem_q[rd_ptr_q]) ^ par_q[rd_ptr_q]);
`else
  assign out_perr = 1'b0;
`endif

endmodule

// File: tb/tb_router_in_queue.sv
// Directed self-checking bench for router_in_queue (DEPTH=4, WIDTH=60).
module tb_router_in_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [59:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [59:0] out_data;
  logic [2:0]  count;
  logic        out_perr;

  int total = 0;
  int bad   = 0;

  router_in_queue #(.DEPTH(4), .WIDTH(60)) dut (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .count    (count),
    .out_perr (out_perr)
  );

  always #5 clk = ~clk;

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    step(); step();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    total++; if (count !== 3'd0) begin bad++; $display("FAIL rst_count got=%0d exp=0", count); end
    total++; if (out_perr !== 1'b0) begin bad++; $display("FAIL rst_perr got=%b exp=0", out_perr); end
    rst = 1'b0;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rel_in_ready_pre got=%b exp=0", in_ready); end
    step();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rel_in_ready got=%b exp=1", in_ready); end
    total++; if (out_valid !== 1'b0 || count !== 3'd0) begin
      bad++; $display("FAIL rel_state got valid=%b count=%0d exp valid=0 count=0", out_valid, count);
    end
  endtask

  task automatic test_fill_two();
    in_valid = 1'b1; in_data = 60'h000000000000001; out_ready = 1'b0;
    step();
    total++; if (out_valid !== 1'b1 || out_data !== 60'h000000000000001) begin
      bad++; $display("FAIL first_push got valid=%b data=%h exp valid=1 data=1", out_valid, out_data);
    end
    in_data = 60'hFFFFFFFFFFFFFFF;
    step();
    in_valid = 1'b0;
    total++; if (count !== 3'd2 || out_data !== 60'h000000000000001) begin
      bad++; $display("FAIL two_push got count=%0d data=%h exp count=2 data=1", count, out_data);
    end
    out_ready = 1'b1;
    step();
    total++; if (out_data !== 60'hFFFFFFFFFFFFFFF || count !== 3'd1) begin
      bad++; $display("FAIL two_pop got count=%0d data=%h exp count=1 data=fff..", count, out_data);
    end
    step();
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0 || count !== 3'd0) begin
      bad++; $display("FAIL two_empty got valid=%b count=%0d exp 0/0", out_valid, count);
    end
  endtask

  task automatic test_full();
    logic [59:0] vec [4];
    vec[0] = 60'h123456789ABCDEF; vec[1] = 60'hA5A5A5A5A5A5A5A;
    vec[2] = 60'h0F0F0F0F0F0F0F0; vec[3] = 60'h800000000000000;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = vec[i];
      step();
    end
    total++; if (count !== 3'd4 || in_ready !== 1'b0) begin
      bad++; $display("FAIL full got count=%0d in_ready=%b exp 4/0", count, in_ready);
    end
    in_data = 60'hDEADBEEFDEADBEE;
    step(); step();
    in_valid = 1'b0;
    total++; if (count !== 3'd4 || out_data !== vec[0]) begin
      bad++; $display("FAIL full_hold got count=%0d data=%h exp 4/%h", count, out_data, vec[0]);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      total++; if (out_valid !== 1'b1 || out_data !== vec[i]) begin
        bad++; $display("FAIL full_order%0d got valid=%b data=%h exp 1/%h", i, out_valid, out_data, vec[i]);
      end
      step();
    end
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0 || count !== 3'd0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL full_drain got valid=%b count=%0d rdy=%b exp 0/0/1", out_valid, count, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [59:0] exp_q [10];
    for (int i = 0; i < 10; i++) exp_q[i] = 60'h100000000000000 * 60'(i + 1) + 60'(i * 7 + 3);
    out_ready = 1'b0; in_valid = 1'b1;
    in_data = exp_q[0]; step();
    in_data = exp_q[1]; step();
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = exp_q[i + 2];
      total++; if (count !== 3'd2 || out_data !== exp_q[i]) begin
        bad++; $display("FAIL b2b%0d got count=%0d data=%h exp 2/%h", i, count, out_data, exp_q[i]);
      end
      step();
    end
    in_valid = 1'b0;
    for (int i = 8; i < 10; i++) begin
      total++; if (out_data !== exp_q[i]) begin
        bad++; $display("FAIL b2b_tail%0d got=%h exp=%h", i, out_data, exp_q[i]);
      end
      step();
    end
    out_ready = 1'b0;
    total++; if (count !== 3'd0) begin bad++; $display("FAIL b2b_empty got=%0d exp=0", count); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 60'(i + 60'h11); step();
    end
    total++; if (count !== 3'd3) begin bad++; $display("FAIL flush_pre got=%0d exp=3", count); end
    flush = 1'b1; out_ready = 1'b1; in_data = 60'hFFFF0000FFFF000;
    step();
    flush = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
    total++; if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++; $display("FAIL flush got count=%0d valid=%b rdy=%b exp 0/0/1", count, out_valid, in_ready);
    end
    in_valid = 1'b1; in_data = 60'h0000000000ABCDE;
    step();
    in_valid = 1'b0;
    total++; if (count !== 3'd1 || out_data !== 60'h0000000000ABCDE) begin
      bad++; $display("FAIL flush_after got count=%0d data=%h exp 1/abcde", count, out_data);
    end
    out_ready = 1'b1; step(); out_ready = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_drop got valid=%b exp=0", out_valid); end
  endtask

  task automatic test_parity();
    in_valid = 1'b1; in_data = 60'h000000000000007; out_ready = 1'b0;
    step();
    in_data = 60'h000000000000003;
    step();
    in_valid = 1'b0;
    total++; if (out_perr !== 1'b0) begin bad++; $display("FAIL perr_clean got=%b exp=0", out_perr); end
`ifdef ROUTER_IN_QUEUE_PARITY_EN
    dut.mem_q[dut.rd_ptr_q][5] = ~dut.mem_q[dut.rd_ptr_q][5];
    #1;
    total++; if (out_perr !== 1'b1) begin bad++; $display("FAIL perr_flip got=%b exp=1", out_perr); end
`endif
    out_ready = 1'b1; step();
    total++; if (out_perr !== 1'b0 || out_data !== 60'h000000000000003) begin
      bad++; $display("FAIL perr_after got perr=%b data=%h exp 0/3", out_perr, out_data);
    end
    step(); out_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    in_valid = 1'b1; in_data = 60'h00000000000BEEF;
    step(); step();
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || count !== 3'd0) begin
      bad++; $display("FAIL async_rst got valid=%b rdy=%b count=%0d exp 0/0/0", out_valid, in_ready, count);
    end
    step();
    rst = 1'b0;
    step();
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL async_rel got rdy=%b valid=%b exp 1/0", in_ready, out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_fill_two();
    test_full();
    test_back_to_back();
    test_flush();
    test_parity();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
